// File: rtl/merge_sort_pkg.sv
// Shared types and constants for the merge-sort engine scheduler.
package merge_sort_pkg;

  localparam int unsigned MSORT_DW    = 8;
  localparam int unsigned MSORT_BEATS = 8;
  localparam int unsigned BLK_ELEMS   = 4 * MSORT_BEATS;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DRAIN} state_e;

  typedef logic signed [MSORT_DW-1:0] elem_t;
  typedef elem_t [3:0] beat_t;

endpackage

// File: rtl/merge_sort_sched_buf.sv
// Block buffer: BEATS x 4*DW register file, written while collecting and read while issuing.
module msort_blk_buf
  import merge_sort_pkg::*;
#(
  parameter int unsigned DW    = MSORT_DW,
  parameter int unsigned BEATS = MSORT_BEATS
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(BEATS)-1:0] wr_addr,
  input  logic [4*DW-1:0]          wr_data,
  input  logic [$clog2(BEATS)-1:0] rd_addr,
  output logic [4*DW-1:0]          rd_data
);

  logic [4*DW-1:0] mem [BEATS];

  // Contents need no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/merge_sort_sched.sv
// Round-robin scheduler sharing one sort engine between two block requesters.
// Optional drain watchdog enabled by defining MSORT_WDOG_EN.
module merge_sort_sched
  import merge_sort_pkg::*;
#(
  parameter int unsigned DW       = MSORT_DW,
  parameter int unsigned BEATS    = MSORT_BEATS,
  parameter int unsigned WDOG_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [4*DW-1:0]      req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [4*DW-1:0]      req1_data,
  output logic                 req1_ready,
  output logic                 eng_blk_in,
  output logic signed [DW-1:0] eng_in1,
  output logic signed [DW-1:0] eng_in2,
  output logic signed [DW-1:0] eng_in3,
  output logic signed [DW-1:0] eng_in4,
  input  logic signed [DW-1:0] eng_sort_out,
  input  logic                 eng_out_valid,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_id,
  output logic                 out_last,
  output logic                 busy,
  output logic                 wdog_err
);

  localparam int unsigned BW = 4 * DW;
  localparam int unsigned NE = 4 * BEATS;
  localparam int unsigned AW = $clog2(BEATS);
  localparam int unsigned EW = $clog2(NE);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_DRAIN   = DRAIN;

  if (BEATS < 2 || WDOG_CYC < 2) begin : g_param_chk
    $error("merge_sort_sched: BEATS and WDOG_CYC must both be at least 2");
  end

  logic [1:0]          state, state_nxt;
  logic                grant, grant_nxt;
  logic                rr, rr_nxt;
  logic [AW-1:0]       beat_cnt, beat_nxt;
  logic [EW-1:0]       elem_cnt, elem_nxt;
  logic                rdy0_nxt, rdy1_nxt, blk_nxt;
  logic [BW-1:0]       eng_nxt;
  logic                ov_nxt, oid_nxt, olast_nxt, busy_nxt;
  logic signed [DW-1:0] od_nxt;
  logic                g_sel, accept;
  logic [BW-1:0]       wr_data, rd_data;

  // Both valid: honour the round-robin pointer; otherwise take whoever asks.
  assign g_sel   = (req0_valid && req1_valid) ? rr : req1_valid;
  assign accept  = (state == S_COLLECT) &&
                   (grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready));
  assign wr_data = grant ? req1_data : req0_data;

  msort_blk_buf #(.DW(DW), .BEATS(BEATS)) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (beat_cnt),
    .wr_data (wr_data),
    .rd_addr (beat_cnt),
    .rd_data (rd_data)
  );

`ifdef MSORT_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wdog_cnt, wdog_cnt_nxt;
  logic          wdog_nxt;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr;
    beat_nxt  = beat_cnt;
    elem_nxt  = elem_cnt;
    rdy0_nxt  = 1'b0;
    rdy1_nxt  = 1'b0;
    blk_nxt   = 1'b0;
    eng_nxt   = {eng_in4, eng_in3, eng_in2, eng_in1};
    ov_nxt    = 1'b0;
    od_nxt    = out_data;
    oid_nxt   = out_id;
    olast_nxt = 1'b0;
`ifdef MSORT_WDOG_EN
    wdog_cnt_nxt = '0;
    wdog_nxt     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_nxt = g_sel;
          rr_nxt    = ~g_sel;
          beat_nxt  = '0;
          state_nxt = S_COLLECT;
          rdy0_nxt  = ~g_sel;
          rdy1_nxt  = g_sel;
        end
      end
      S_COLLECT: begin
        rdy0_nxt = ~grant;
        rdy1_nxt = grant;
        if (accept) begin
          beat_nxt = beat_cnt + AW'(1);
          if (beat_cnt == AW'(BEATS - 1)) begin
            beat_nxt  = '0;
            state_nxt = S_ISSUE;
            rdy0_nxt  = 1'b0;
            rdy1_nxt  = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        eng_nxt  = rd_data;
        blk_nxt  = (beat_cnt == '0);
        beat_nxt = beat_cnt + AW'(1);
        if (beat_cnt == AW'(BEATS - 1)) begin
          beat_nxt  = '0;
          elem_nxt  = '0;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (eng_out_valid) begin
          ov_nxt   = 1'b1;
          od_nxt   = eng_sort_out;
          oid_nxt  = grant;
          elem_nxt = elem_cnt + EW'(1);
          if (elem_cnt == EW'(NE - 1)) begin
            olast_nxt = 1'b1;
            elem_nxt  = '0;
            state_nxt = S_IDLE;
          end
        end
`ifdef MSORT_WDOG_EN
        // A stalled engine abandons the block; downstream drops the partial data.
        else if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
          wdog_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wdog_cnt_nxt = wdog_cnt + WW'(1);
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      rr         <= 1'b0;
      beat_cnt   <= '0;
      elem_cnt   <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      eng_blk_in <= 1'b0;
      eng_in1    <= '0;
      eng_in2    <= '0;
      eng_in3    <= '0;
      eng_in4    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr         <= rr_nxt;
      beat_cnt   <= beat_nxt;
      elem_cnt   <= elem_nxt;
      req0_ready <= rdy0_nxt;
      req1_ready <= rdy1_nxt;
      eng_blk_in <= blk_nxt;
      eng_in1    <= eng_nxt[DW-1:0];
      eng_in2    <= eng_nxt[2*DW-1:DW];
      eng_in3    <= eng_nxt[3*DW-1:2*DW];
      eng_in4    <= eng_nxt[4*DW-1:3*DW];
      out_valid  <= ov_nxt;
      out_data   <= od_nxt;
      out_id     <= oid_nxt;
      out_last   <= olast_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef MSORT_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_nxt;
      wdog_err <= wdog_nxt;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_sort_sched.sv
// Randomized scoreboard bench for merge_sort_sched with a behavioural sort-engine model.
module tb_merge_sort_sched;
  import merge_sort_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned BEATS = 8;
  localparam int unsigned NE = BLK_ELEMS;
  localparam int unsigned BLKW = 4 * DW * BEATS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4*DW-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, eng_blk_in;
  logic signed [DW-1:0] eng_in1, eng_in2, eng_in3, eng_in4;
  logic signed [DW-1:0] eng_sort_out;
  logic eng_out_valid;
  logic out_valid, out_id, out_last, busy, wdog_err;
  logic signed [DW-1:0] out_data;

  merge_sort_sched #(.DW(DW), .BEATS(BEATS), .WDOG_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .eng_blk_in(eng_blk_in), .eng_in1(eng_in1), .eng_in2(eng_in2),
    .eng_in3(eng_in3), .eng_in4(eng_in4),
    .eng_sort_out(eng_sort_out), .eng_out_valid(eng_out_valid),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    byte d;
    bit  id;
    bit  last;
  } exp_t;

  exp_t           exp_q[$];
  logic [BLKW-1:0] blk_q[$];
  int             grant_log[$];
  int             exp_grants[$];
  int checks = 0, passes = 0;
  int both_rdy = 0, out_seen = 0;
  int stray_req = 0, eng_limit = NE, last_drive_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic v, input logic [4*DW-1:0] d);
    if (r == 0) begin req0_valid = v; req0_data = d; end
    else        begin req1_valid = v; req1_data = d; end
  endtask

  // mode 0: contiguous, 1: 2-cycle gaps after beats 3 and 5, 2: random gaps
  task automatic drive_block(input int r, input int mode);
    logic [BLKW-1:0] flat;
    logic [4*DW-1:0] b;
    byte vals[$];
    bit acc, rdy;
    int n;
    for (int k = 0; k < int'(BEATS); k++) flat[32*k +: 32] = $urandom;
    for (int k = 0; k < int'(BEATS); k++) begin
      b = flat[32*k +: 32];
      set_req(r, 1'b1, b);
      acc = 1'b0;
      for (int t = 0; t < 4000 && !acc; t++) begin
        @(negedge clk);
        rdy = (r == 0) ? req0_ready : req1_ready;
        @(posedge clk);
        #1;
        acc = rdy;
      end
      if (!acc) begin
        chk("beat_accept_timeout", 64'(acc), 64'd1);
        set_req(r, 1'b0, '0);
        return;
      end
      if (k == 0) begin
        blk_q.push_back(flat);
        grant_log.push_back(r);
        vals.delete();
        for (int i = 0; i < int'(NE); i++) vals.push_back(byte'(flat[8*i +: 8]));
        vals.sort();
        for (int i = 0; i < int'(NE); i++)
          exp_q.push_back('{d: vals[i], id: r[0], last: (i == int'(NE) - 1)});
      end
      n = 0;
      if (mode == 1 && (k == 3 || k == 5)) n = 2;
      if (mode == 2) n = $urandom_range(0, 2);
      if (n > 0 && k < int'(BEATS) - 1) begin
        set_req(r, 1'b0, b);
        repeat (n) begin @(posedge clk); #1; end
      end
    end
    set_req(r, 1'b0, '0);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Sort-engine model: captures a BlkIn-framed burst, sorts it, streams it back with gaps.
  initial begin
    logic [BLKW-1:0] cap, expb;
    byte vals[$];
    int stray_done, mism, n;
    bit burst_ok, aborted;
    eng_out_valid = 1'b0;
    eng_sort_out  = '0;
    stray_done    = 0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        stray_done++;
        @(posedge clk); #1;
        eng_out_valid = 1'b1;
        eng_sort_out  = -8'sd128;
        @(posedge clk); #1;
        eng_out_valid = 1'b0;
      end else if (!rst && eng_blk_in) begin
        cap[31:0] = {eng_in4, eng_in3, eng_in2, eng_in1};
        burst_ok = 1'b1;
        aborted  = 1'b0;
        for (int j = 1; j < int'(BEATS) && !aborted; j++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (eng_blk_in) burst_ok = 1'b0;
          cap[32*j +: 32] = {eng_in4, eng_in3, eng_in2, eng_in1};
        end
        if (aborted) begin
          if (blk_q.size() > 0) void'(blk_q.pop_front());
        end else if (blk_q.size() == 0) begin
          chk("eng_burst_unexpected", 64'd1, 64'd0);
        end else begin
          expb = blk_q.pop_front();
          mism = burst_ok ? 0 : 100;
          for (int k = 0; k < int'(BEATS); k++)
            if (cap[32*k +: 32] !== expb[32*k +: 32]) mism++;
          chk("eng_burst", 64'(mism), 64'd0);
          vals.delete();
          for (int i = 0; i < int'(NE); i++) vals.push_back(byte'(cap[8*i +: 8]));
          vals.sort();
          n = (eng_limit < int'(NE)) ? eng_limit : int'(NE);
          for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            eng_out_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            eng_out_valid  = 1'b1;
            eng_sort_out   = vals[i];
            last_drive_cyc = cyc;
          end
          @(posedge clk); #1;
          eng_out_valid = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every presented element.
  always @(negedge clk) begin
    exp_t e;
    if (req0_ready && req1_ready) both_rdy <= both_rdy + 1;
    if (out_valid) begin
      out_seen <= out_seen + 1;
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {out_id, out_last, 8'(out_data)}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_data === e.d && out_id === e.id && out_last === e.last) passes++;
        else $display("FAIL out_elem: got d=%0d id=%0d last=%0d, expected d=%0d id=%0d last=%0d",
                      out_data, out_id, out_last, e.d, e.id, e.last);
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({req0_ready, req1_ready, eng_blk_in, eng_in1, eng_in2, eng_in3, eng_in4,
                out_valid, out_data, out_id, out_last, busy, wdog_err});
  endfunction

  initial begin
    int r, seen, base;
    bit hit;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);

    drive_block(0, 0); exp_grants.push_back(0);
    wait_done("t1_done");
    drive_block(0, 1); exp_grants.push_back(0);
    wait_done("t2_gaps_done");
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 1);
      drive_block(r, 2); exp_grants.push_back(r);
      wait_done("rand_done");
    end

    // Stray engine output while idle must be ignored.
    base = out_seen;
    stray_req++;
    repeat (6) @(negedge clk);
    chk("stray_no_out", 64'(out_seen - base), 64'd0);
    chk("stray_idle", 64'(busy), 64'd0);

    // Reset in the middle of the engine burst.
    drive_block(0, 0); exp_grants.push_back(0);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      hit = eng_blk_in;
    end
    chk("issue_start", 64'(hit), 64'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    base = out_seen;

    // Both requesters continuously valid for three blocks.
    fork
      begin drive_block(0, 0); drive_block(0, 0); end
      begin drive_block(1, 0); end
    join
    exp_grants.push_back(0); exp_grants.push_back(1); exp_grants.push_back(0);
    wait_done("t3_done");
    chk("t3_outs", 64'(out_seen - base), 64'(3 * NE));
    chk("ready_exclusive", 64'(both_rdy), 64'd0);
    chk("grant_count", 64'(grant_log.size()), 64'(exp_grants.size()));
    for (int i = 0; i < grant_log.size() && i < exp_grants.size(); i++)
      chk("grant_order", 64'(grant_log[i]), 64'(exp_grants[i]));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Engine stalls after 10 outputs.
    eng_limit = 10;
    base = out_seen;
    drive_block(0, 2);
`ifdef MSORT_WDOG_EN
    seen = -1;
    for (int t = 0; t < 600 && seen < 0; t++) begin
      @(negedge clk);
      if (wdog_err) seen = cyc;
    end
    chk("wdog_cycle", 64'(seen), 64'(last_drive_cyc + 65));
    @(negedge clk);
    chk("wdog_pulse_1cyc", 64'({wdog_err, busy}), 64'd0);
`else
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (wdog_err) seen++;
    end
    chk("nowdog_busy_hold", 64'(busy), 64'd1);
    chk("nowdog_err_zero", 64'(seen), 64'd0);
`endif
    chk("stall_outs", 64'(out_seen - base), 64'd10);
    exp_q.delete();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
